// File: rtl/upsample_pkg.sv
// upsample_pkg: shared defaults and FSM state encoding for the upsample block.
// The REPLAY states exist only when UPSAMPLE_ROW_REPEAT_EN is defined.
package upsample_pkg;

    localparam int UPS_DWIDTH_DEF  = 20;
    localparam int UPS_MAX_ROW_DEF = 64;
    localparam int UPS_LWIDTH_DEF  = 7;

`ifdef UPSAMPLE_ROW_REPEAT_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMIT0   = 3'd1,
        EMIT1   = 3'd2,
        REPLAY0 = 3'd3,
        REPLAY1 = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/upsample_linebuf.sv
// upsample_linebuf: DEPTH x DWIDTH row store, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
// Out-of-range addresses are ignored on write and read back as zero.
module upsample_linebuf #(
    parameter int DWIDTH = 20,
    parameter int DEPTH  = 64,
    parameter int AWIDTH = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] r_mem [0:DEPTH-1];
    logic [IW-1:0]     w_widx;
    logic [IW-1:0]     w_ridx;
    logic              w_wok;
    logic              w_rok;

    assign w_wok   = (i_waddr < AWIDTH'(DEPTH));
    assign w_rok   = (i_raddr < AWIDTH'(DEPTH));
    assign w_widx  = i_waddr[IW-1:0];
    assign w_ridx  = i_raddr[IW-1:0];
    assign o_rdata = w_rok ? r_mem[w_ridx] : {DWIDTH{1'b0}};

    // Row storage write; no reset so the array maps onto plain memory.
    always_ff @(posedge clk) begin
        if (i_we && w_wok) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

endmodule

// File: rtl/upsample.sv
// upsample: 2x nearest-neighbour upsampler (each accepted word is emitted twice)
// with a bypass mode, valid/ready on both sides and a registered output stage.
// Build option: define UPSAMPLE_ROW_REPEAT_EN for 2D upsampling, where every
// completed row is replayed from a line buffer (each word twice again).
module upsample
    import upsample_pkg::*;
#(
    parameter int DWIDTH  = UPS_DWIDTH_DEF,
    parameter int MAX_ROW = UPS_MAX_ROW_DEF,
    parameter int LWIDTH  = UPS_LWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_upsample,
    input  logic [LWIDTH-1:0] row_len,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_out
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DWIDTH-1:0] r_data;
    logic [DWIDTH-1:0] w_data_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              w_ready_in;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_row_end;

    assign w_out_xfer = r_valid & ready_out;
    assign w_in_xfer  = valid_in & w_ready_in;
    assign ready_in   = w_ready_in;
    assign data_out   = r_data;
    assign valid_out  = r_valid;

`ifdef UPSAMPLE_ROW_REPEAT_EN
    localparam logic [LWIDTH-1:0] LEN_ONE = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(MAX_ROW);

    logic [LWIDTH-1:0] r_col;
    logic [LWIDTH-1:0] w_col_nxt;
    logic [LWIDTH-1:0] r_len;
    logic [LWIDTH-1:0] w_len_nxt;
    logic [LWIDTH-1:0] r_rep;
    logic [LWIDTH-1:0] w_rep_nxt;
    logic [LWIDTH-1:0] w_buf_raddr;
    logic [DWIDTH-1:0] w_buf_rdata;
    logic              w_buf_we;

    // Row length as latched: zero means one pixel, oversize rows are capped.
    function automatic logic [LWIDTH-1:0] clamp_len(input logic [LWIDTH-1:0] len);
        logic [LWIDTH-1:0] res;
        if (len == {LWIDTH{1'b0}}) begin
            res = LEN_ONE;
        end else if (len > LEN_MAX) begin
            res = LEN_MAX;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // r_col counts words already taken for this row, so the row is complete
    // once it reaches the latched length.
    assign w_row_end = (r_col == r_len);
    // Only upsampled words belong to a row; bypassed words never touch the buffer.
    assign w_buf_we  = w_in_xfer & en_upsample;

    upsample_linebuf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_ROW),
        .AWIDTH (LWIDTH)
    ) u_linebuf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_col),
        .i_wdata (data_in),
        .i_raddr (w_buf_raddr),
        .o_rdata (w_buf_rdata)
    );

    // Replay read address: entry 0 when a row starts replaying, else the next entry.
    always_comb begin
        w_buf_raddr = {LWIDTH{1'b0}};
        if (r_state == REPLAY1) begin
            w_buf_raddr = r_rep + LEN_ONE;
        end else begin
            w_buf_raddr = {LWIDTH{1'b0}};
        end
    end
`else
    logic w_unused_cfg;

    assign w_row_end    = 1'b0;
    assign w_unused_cfg = (^row_len) | (MAX_ROW == 0);
`endif

    // Input-side ready: held low during reset, while a copy is pending and during replay.
    always_comb begin
        w_ready_in = 1'b0;
        if (!reset_n) begin
            w_ready_in = 1'b0;
        end else begin
            case (r_state)
                IDLE:    w_ready_in = ~r_valid | ready_out;
                EMIT0:   w_ready_in = 1'b0;
                EMIT1:   w_ready_in = ready_out & ~w_row_end;
                default: w_ready_in = 1'b0;
            endcase
        end
    end

    // Next-state and output-register logic; en_upsample is consulted only when a word is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
`ifdef UPSAMPLE_ROW_REPEAT_EN
        w_col_nxt   = r_col;
        w_len_nxt   = r_len;
        w_rep_nxt   = r_rep;
        if (w_buf_we) begin
            w_col_nxt = r_col + LEN_ONE;
            if (r_col == {LWIDTH{1'b0}}) begin
                w_len_nxt = clamp_len(row_len);
            end else begin
                w_len_nxt = r_len;
            end
        end else begin
            w_col_nxt = r_col;
        end
`endif
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_data_nxt  = data_in;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = en_upsample ? EMIT0 : IDLE;
                end else if (w_out_xfer) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            EMIT0: begin
                if (w_out_xfer) begin
                    w_state_nxt = EMIT1;
                end else begin
                    w_state_nxt = EMIT0;
                end
            end
            EMIT1: begin
                if (w_out_xfer && w_row_end) begin
`ifdef UPSAMPLE_ROW_REPEAT_EN
                    w_data_nxt  = w_buf_rdata;
                    w_rep_nxt   = {LWIDTH{1'b0}};
                    w_state_nxt = REPLAY0;
`else
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
`endif
                end else if (w_in_xfer) begin
                    w_data_nxt  = data_in;
                    w_state_nxt = en_upsample ? EMIT0 : IDLE;
                end else if (w_out_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = EMIT1;
                end
            end
`ifdef UPSAMPLE_ROW_REPEAT_EN
            REPLAY0: begin
                if (w_out_xfer) begin
                    w_state_nxt = REPLAY1;
                end else begin
                    w_state_nxt = REPLAY0;
                end
            end
            REPLAY1: begin
                if (w_out_xfer) begin
                    if (r_rep == (r_len - LEN_ONE)) begin
                        w_valid_nxt = 1'b0;
                        w_col_nxt   = {LWIDTH{1'b0}};
                        w_state_nxt = IDLE;
                    end else begin
                        w_rep_nxt   = r_rep + LEN_ONE;
                        w_data_nxt  = w_buf_rdata;
                        w_state_nxt = REPLAY0;
                    end
                end else begin
                    w_state_nxt = REPLAY1;
                end
            end
`endif
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and output register; reset drops any pair in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_data  <= {DWIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef UPSAMPLE_ROW_REPEAT_EN
    // Row bookkeeping: column counter, latched row length, replay index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= {LWIDTH{1'b0}};
            r_len <= LEN_ONE;
            r_rep <= {LWIDTH{1'b0}};
        end else begin
            r_col <= w_col_nxt;
            r_len <= w_len_nxt;
            r_rep <= w_rep_nxt;
        end
    end
`endif

endmodule
